// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit
// Instruction fetch stage: owns the fetch PC, requests words from instruction
// memory over a req/ack handshake, buffers them in a circular prefetch queue
// and presents the head instruction to decode. Branch/jump redirects flush the
// queue and restart fetching at the target; a request already in flight when
// the redirect arrives is completed and its data discarded (DROP state).
//
// Optional feature macro: FETCH_BYPASS_EN
//   defined   - an acked word is forwarded combinationally to the Inst* outputs
//               when the queue is empty (0-cycle ack-to-valid latency).
//   undefined - every word passes through the queue (1-cycle latency).
//
// state  | meaning
// S_IDLE | no request outstanding; waits for queue room
// S_WAIT | request outstanding at IMemAddr for the sequential fetch PC
// S_DROP | stale request outstanding; its data is discarded, target in r_tgt
module fetch_prefetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  output logic [31:0] Instruction,
  output logic [31:0] InstPC,
  output logic        InstValid,
  input  logic        InstReady,
  input  logic        BranchTaken,
  input  logic [31:0] BranchOffset,
  input  logic        Jump,
  input  logic [25:0] JumpTarget
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_addr;
  logic [31:0]   w_addr_nxt;
  logic [31:0]   r_tgt;
  logic [31:0]   w_tgt_nxt;

  logic [31:0]   r_qdata [DEPTH];
  logic [31:0]   r_qpc   [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;

  logic          w_q_valid;
  logic          w_byp;
  logic          w_consume;
  logic          w_redirect;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_seq_pc;
  logic [31:0]   w_target;

  assign w_q_valid = (r_count != '0);
  assign IMemReq   = (r_state != S_IDLE);
  assign IMemAddr  = r_addr;

`ifdef FETCH_BYPASS_EN
  // Forward the acked word straight to decode when nothing is queued ahead of it
  always_comb begin
    w_byp       = (r_state == S_WAIT) && IMemAck && !w_q_valid;
    InstValid   = w_q_valid || w_byp;
    Instruction = 32'h0;
    InstPC      = 32'h0;
    if (w_q_valid) begin
      Instruction = r_qdata[r_rptr];
      InstPC      = r_qpc[r_rptr];
    end else if (w_byp) begin
      Instruction = IMemData;
      InstPC      = IMemAddr;
    end
  end
`else
  // Head of the queue drives decode; all-zero NOOP when the queue is empty
  always_comb begin
    w_byp       = 1'b0;
    InstValid   = w_q_valid;
    Instruction = 32'h0;
    InstPC      = 32'h0;
    if (w_q_valid) begin
      Instruction = r_qdata[r_rptr];
      InstPC      = r_qpc[r_rptr];
    end
  end
`endif

  // Redirect detection and target arithmetic (jump wins over branch)
  always_comb begin
    w_consume  = InstValid && InstReady;
    w_redirect = w_consume && (Jump || BranchTaken);
    w_seq_pc   = InstPC + 32'd4;
    if (Jump) begin
      w_target = {w_seq_pc[31:28], JumpTarget, 2'b00};
    end else begin
      w_target = w_seq_pc + (BranchOffset << 2);
    end
  end

  // Queue push/pop decisions; a bypassed word consumed in its ack cycle is not stored
  always_comb begin
    w_push      = (r_state == S_WAIT) && IMemAck && !w_redirect && !(w_byp && w_consume);
    w_pop       = w_consume && w_q_valid;
    w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
  end

  // Fetch FSM next-state, next request address and pending redirect target
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_tgt_nxt   = r_tgt;
    case (r_state)
      S_IDLE: begin
        if (w_redirect) begin
          w_addr_nxt  = w_target;
          w_state_nxt = S_WAIT;
        end else if (r_count < DEPTH_C) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_redirect) begin
          if (IMemAck) begin
            w_addr_nxt  = w_target;
            w_state_nxt = S_WAIT;
          end else begin
            w_tgt_nxt   = w_target;
            w_state_nxt = S_DROP;
          end
        end else if (IMemAck) begin
          w_addr_nxt  = r_addr + 32'd4;
          w_state_nxt = (w_count_nxt < DEPTH_C) ? S_WAIT : S_IDLE;
        end
      end
      S_DROP: begin
        if (w_redirect) begin
          if (IMemAck) begin
            w_addr_nxt  = w_target;
            w_state_nxt = S_WAIT;
          end else begin
            w_tgt_nxt   = w_target;
          end
        end else if (IMemAck) begin
          w_addr_nxt  = r_tgt;
          w_state_nxt = S_WAIT;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state and address registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_addr  <= RESET_PC;
      r_tgt   <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_tgt   <= w_tgt_nxt;
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_redirect) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_count <= w_count_nxt;
    end
  end

  // Queue storage; contents are only observed through valid entries
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_qdata[r_wptr] <= IMemData;
      r_qpc[r_wptr]   <= r_addr;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit (default build, queue latency 1).
// Each table row is one clock cycle: inputs applied after the falling edge,
// outputs compared 1 ns later. Memory returns addr ^ 32'hC0DE_0001.
module tb_fetch_prefetch_unit;

  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemAck;
  logic [31:0] IMemData;
  logic [31:0] Instruction;
  logic [31:0] InstPC;
  logic        InstValid;
  logic        InstReady;
  logic        BranchTaken;
  logic [31:0] BranchOffset;
  logic        Jump;
  logic [25:0] JumpTarget;

  int n_checks = 0;
  int n_errors = 0;

  fetch_prefetch_unit #(.RESET_PC(RPC), .DEPTH(4)) dut (
    .Clk(Clk), .Reset(Reset),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemAck(IMemAck), .IMemData(IMemData),
    .Instruction(Instruction), .InstPC(InstPC), .InstValid(InstValid), .InstReady(InstReady),
    .BranchTaken(BranchTaken), .BranchOffset(BranchOffset), .Jump(Jump), .JumpTarget(JumpTarget)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0001;
  endfunction

  assign IMemData = mem_word(IMemAddr);

  typedef struct {
    logic        ack;
    logic        rdy;
    logic        br;
    logic [31:0] off;
    logic        jmp;
    logic [25:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc;
  } vec_t;

  localparam int NV = 33;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic ack, input logic rdy, input logic br,
                              input logic [31:0] off, input logic jmp, input logic [25:0] tgt,
                              input logic req, input logic [31:0] addr,
                              input logic vld, input logic [31:0] pc);
    vec_t v;
    v.ack = ack; v.rdy = rdy; v.br = br; v.off = off; v.jmp = jmp; v.tgt = tgt;
    v.e_req = req; v.e_addr = addr; v.e_vld = vld; v.e_pc = pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic req, input logic [31:0] addr,
                          input logic vld, input logic [31:0] pc);
    logic [31:0] e_ins;
    e_ins = vld ? mem_word(pc) : 32'h0;
    chk({tag, "_req"},   32'(IMemReq),   32'(req));
    chk({tag, "_addr"},  IMemAddr,       addr);
    chk({tag, "_valid"}, 32'(InstValid), 32'(vld));
    chk({tag, "_pc"},    InstPC,         vld ? pc : 32'h0);
    chk({tag, "_instr"}, Instruction,    e_ins);
  endtask

  initial begin
    //                ack rdy br  off            jmp tgt       req addr           vld pc
    // fill from reset with decode stalled: exactly four acks, then IMemReq drops
    vecs[0]  = mk(0, 0, 0, 32'h0,        0, 26'h0,   0, RPC,            0, 32'h0);
    vecs[1]  = mk(1, 0, 0, 32'h0,        0, 26'h0,   1, RPC,            0, 32'h0);
    vecs[2]  = mk(1, 0, 0, 32'h0,        0, 26'h0,   1, 32'h0040_0004,  1, RPC);
    vecs[3]  = mk(1, 0, 0, 32'h0,        0, 26'h0,   1, 32'h0040_0008,  1, RPC);
    vecs[4]  = mk(1, 0, 0, 32'h0,        0, 26'h0,   1, 32'h0040_000C,  1, RPC);
    vecs[5]  = mk(1, 0, 0, 32'h0,        0, 26'h0,   0, 32'h0040_0010,  1, RPC);
    vecs[6]  = mk(0, 0, 0, 32'h0,        0, 26'h0,   0, 32'h0040_0010,  1, RPC);
    // drain, refill, then one instruction per cycle
    vecs[7]  = mk(0, 1, 0, 32'h0,        0, 26'h0,   0, 32'h0040_0010,  1, RPC);
    vecs[8]  = mk(0, 1, 0, 32'h0,        0, 26'h0,   0, 32'h0040_0010,  1, 32'h0040_0004);
    vecs[9]  = mk(1, 1, 0, 32'h0,        0, 26'h0,   1, 32'h0040_0010,  1, 32'h0040_0008);
    vecs[10] = mk(1, 1, 0, 32'h0,        0, 26'h0,   1, 32'h0040_0014,  1, 32'h0040_000C);
    vecs[11] = mk(1, 1, 0, 32'h0,        0, 26'h0,   1, 32'h0040_0018,  1, 32'h0040_0010);
    // jump coincident with ack -> target 0x100 next cycle, queue flushed
    vecs[12] = mk(1, 1, 0, 32'h0,        1, 26'h40,  1, 32'h0040_001C,  1, 32'h0040_0014);
    // jump while InstValid=0 is ignored
    vecs[13] = mk(1, 1, 0, 32'h0,        1, 26'h3FF, 1, 32'h0000_0100,  0, 32'h0);
    // branch at 0x100, offset -2 -> 0xFC
    vecs[14] = mk(1, 1, 1, 32'hFFFF_FFFE, 0, 26'h0,  1, 32'h0000_0104,  1, 32'h0000_0100);
    vecs[15] = mk(1, 1, 0, 32'h0,        0, 26'h0,   1, 32'h0000_00FC,  0, 32'h0);
    vecs[16] = mk(1, 1, 0, 32'h0,        0, 26'h0,   1, 32'h0000_0100,  1, 32'h0000_00FC);
    // branch while memory stalls: address held 3 cycles, data dropped, then 0x114
    vecs[17] = mk(0, 1, 1, 32'h4,        0, 26'h0,   1, 32'h0000_0104,  1, 32'h0000_0100);
    vecs[18] = mk(0, 1, 0, 32'h0,        0, 26'h0,   1, 32'h0000_0104,  0, 32'h0);
    vecs[19] = mk(0, 1, 0, 32'h0,        0, 26'h0,   1, 32'h0000_0104,  0, 32'h0);
    vecs[20] = mk(1, 1, 0, 32'h0,        0, 26'h0,   1, 32'h0000_0104,  0, 32'h0);
    vecs[21] = mk(1, 1, 0, 32'h0,        0, 26'h0,   1, 32'h0000_0114,  0, 32'h0);
    // long branch into the 0x1000_0000 region via DROP
    vecs[22] = mk(0, 1, 1, 32'h03FF_FFBE, 0, 26'h0,  1, 32'h0000_0118,  1, 32'h0000_0114);
    vecs[23] = mk(1, 1, 0, 32'h0,        0, 26'h0,   1, 32'h0000_0118,  0, 32'h0);
    vecs[24] = mk(1, 1, 0, 32'h0,        0, 26'h0,   1, 32'h1000_0010,  0, 32'h0);
    // jump at 0x1000_0010, target field 0x40 -> 0x1000_0100
    vecs[25] = mk(1, 1, 0, 32'h0,        1, 26'h40,  1, 32'h1000_0014,  1, 32'h1000_0010);
    vecs[26] = mk(1, 1, 0, 32'h0,        0, 26'h0,   1, 32'h1000_0100,  0, 32'h0);
    // branch to 0xFFFF_FFF8 (address arithmetic modulo 2^32), then PC wraps to 0
    vecs[27] = mk(0, 1, 1, 32'hFBFF_FFBD, 0, 26'h0,  1, 32'h1000_0104,  1, 32'h1000_0100);
    vecs[28] = mk(1, 1, 0, 32'h0,        0, 26'h0,   1, 32'h1000_0104,  0, 32'h0);
    vecs[29] = mk(1, 0, 0, 32'h0,        0, 26'h0,   1, 32'hFFFF_FFF8,  0, 32'h0);
    vecs[30] = mk(1, 0, 0, 32'h0,        0, 26'h0,   1, 32'hFFFF_FFFC,  1, 32'hFFFF_FFF8);
    vecs[31] = mk(1, 1, 0, 32'h0,        0, 26'h0,   1, 32'h0000_0000,  1, 32'hFFFF_FFF8);
    vecs[32] = mk(0, 0, 0, 32'h0,        0, 26'h0,   1, 32'h0000_0004,  1, 32'hFFFF_FFFC);

    Reset = 1'b1;
    IMemAck = 1'b0; InstReady = 1'b0; BranchTaken = 1'b0;
    BranchOffset = 32'h0; Jump = 1'b0; JumpTarget = 26'h0;

    repeat (2) @(negedge Clk);
    #1;
    chk_outs("reset", 1'b0, RPC, 1'b0, 32'h0);
    @(negedge Clk);
    Reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      IMemAck      = vecs[i].ack;
      InstReady    = vecs[i].rdy;
      BranchTaken  = vecs[i].br;
      BranchOffset = vecs[i].off;
      Jump         = vecs[i].jmp;
      JumpTarget   = vecs[i].tgt;
      #1;
      chk_outs($sformatf("row%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_vld, vecs[i].e_pc);
      @(negedge Clk);
    end

    // Reset asserted mid-cycle while a request is outstanding and two words are queued
    IMemAck = 1'b0; InstReady = 1'b0; BranchTaken = 1'b0; Jump = 1'b0;
    #1;
    chk_outs("pre_rst", 1'b1, 32'h0000_0004, 1'b1, 32'hFFFF_FFFC);
    Reset = 1'b1;
    #1;
    chk_outs("mid_rst", 1'b0, RPC, 1'b0, 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    InstReady = 1'b1;
    #1;
    chk_outs("rst_idle", 1'b0, RPC, 1'b0, 32'h0);
    @(negedge Clk);
    IMemAck = 1'b1;
    #1;
    chk_outs("rst_req0", 1'b1, RPC, 1'b0, 32'h0);
    @(negedge Clk);
    #1;
    chk_outs("rst_req1", 1'b1, 32'h0040_0004, 1'b1, RPC);
    @(negedge Clk);
    #1;
    chk_outs("rst_req2", 1'b1, 32'h0040_0008, 1'b1, 32'h0040_0004);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
